mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_align.sv | 47 ++++
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: writeback select codes, FSM states, access sizes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    // Writeback select encoding; loads use it to pick size and extension,
    // stores only use the three size codes.
    localparam logic [2:0] WB_SB  = 3'd0;
    localparam logic [2:0] WB_SH  = 3'd1;
    localparam logic [2:0] WB_W   = 3'd2;
    localparam logic [2:0] WB_ALU = 3'd3;
    localparam logic [2:0] WB_UB  = 3'd4;
    localparam logic [2:0] WB_UH  = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    // Access size implied by a writeback select; anything that is not a
    // byte or half code is treated as a full word.
    function automatic mem_size_t size_of(input logic [2:0] wbs_code);
        mem_size_t sz;
        case (wbs_code)
            WB_SB, WB_UB: sz = SZ_BYTE;
            WB_SH, WB_UH: sz = SZ_HALF;
            default:      sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Natural alignment check on the low address bits.
    function automatic logic misaligned(input mem_size_t sz, input logic [1:0] addr_lo);
        logic bad;
        case (sz)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the memory.
// Latency: request held until mem_ack; read data valid in the ack cycle.
// Backpressure: memory stretches the access by withholding mem_ack.
interface mem_stage_if #(parameter int WordSize = 32);
    logic                mem_req;
    logic                mem_we;
    logic [WordSize-1:0] mem_addr;
    logic [3:0]          mem_be;
    logic [WordSize-1:0] mem_wdata;
    logic                mem_ack;
    logic [WordSize-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane logic: byte enables, store data replication, load lane extraction.
// Latency: purely combinational.
// Backpressure: none.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  mem_size_t           size,
    input  logic [1:0]          addr_lo,
    input  logic [WordSize-1:0] st_data,
    input  logic [WordSize-1:0] rdata,
    output logic [3:0]          be,
    output logic [WordSize-1:0] wdata,
    output logic [WordSize-1:0] rdata_ext
);

    logic [WordSize-1:0] rdata_shift;

    // Bring the addressed lane down to bit 0; word accesses are aligned so the shift is zero.
    assign rdata_shift = rdata >> {addr_lo, 3'b000};

    // Lane selection per access size; upper result bits stay zero so writeback owns extension.
    always_comb begin
        be        = 4'b1111;
        wdata     = st_data;
        rdata_ext = rdata_shift;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{st_data[7:0]}};
                rdata_ext = {{(WordSize-8){1'b0}}, rdata_shift[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{st_data[15:0]}};
                rdata_ext = {{(WordSize-16){1'b0}}, rdata_shift[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata     = st_data;
                rdata_ext = rdata_shift;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results, performs one load/store at a time on the data bus.
// Latency: 1 cycle for ALU ops; loads/stores retire on the mem_ack edge.
// Backpressure: stall high while an access waits for mem_ack; upstream op is taken once back in IDLE.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_in,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          wbs_in,
    input  logic [4:0]          rdn_in,
    input  logic [WordSize-1:0] alu_in,
    input  logic [WordSize-1:0] st_data,
    output logic                stall,
    output logic                misalign,
    mem_stage_if.master         mem,
    output logic [2:0]          wbs,
    output logic [4:0]          rdn,
    output logic [WordSize-1:0] alu_out,
    output logic [WordSize-1:0] mrd
);

    state_t              state_q, state_d;
    logic                access;
    logic                cap_en;
    logic                cap_load;
    logic [2:0]          cap_wbs;
    logic [4:0]          cap_rdn;
    logic [WordSize-1:0] cap_addr;
    logic [WordSize-1:0] cap_data;
    mem_size_t           cap_size;

    logic [2:0]          wbs_d;
    logic [4:0]          rdn_d;
    logic [WordSize-1:0] alu_d;
    logic [WordSize-1:0] mrd_d;
    logic                mis_d;

    logic [3:0]          lane_be;
    logic [WordSize-1:0] lane_wdata;
    logic [WordSize-1:0] rdata_ext;

    assign access   = (state_q == ST_ACCESS);
    assign cap_size = size_of(cap_wbs);

    mem_align #(.WordSize(WordSize)) u_align (
        .size      (cap_size),
        .addr_lo   (cap_addr[1:0]),
        .st_data   (cap_data),
        .rdata     (mem.mem_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .rdata_ext (rdata_ext)
    );

    // Bus outputs come only from the captured op and are zero outside an access,
    // so an asynchronous reset drops the request immediately.
    assign mem.mem_req   = access;
    assign mem.mem_we    = access & ~cap_load;
    assign mem.mem_addr  = access ? {cap_addr[WordSize-1:2], 2'b00} : '0;
    assign mem.mem_be    = access ? lane_be : 4'b0000;
    assign mem.mem_wdata = access ? lane_wdata : '0;
    assign stall         = access & ~mem.mem_ack;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, capture enable and next writeback values; bubble unless something retires.
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        wbs_d   = WB_ALU;
        rdn_d   = '0;
        alu_d   = '0;
        mrd_d   = '0;
        mis_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (!(is_load || is_store)) begin
                        wbs_d = wbs_in;
                        rdn_d = rdn_in;
                        alu_d = alu_in;
                    end else if (misaligned(size_of(wbs_in), alu_in[1:0])) begin
                        mis_d = 1'b1;
                    end else begin
                        cap_en  = 1'b1;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    state_d = ST_IDLE;
                    if (cap_load) begin
                        wbs_d = cap_wbs;
                        rdn_d = cap_rdn;
                        alu_d = cap_addr;
                        mrd_d = rdata_ext;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the accepted memory op; a simultaneous load+store flag is a load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_load <= 1'b0;
            cap_wbs  <= WB_ALU;
            cap_rdn  <= '0;
            cap_addr <= '0;
            cap_data <= '0;
        end else if (cap_en) begin
            cap_load <= is_load;
            cap_wbs  <= wbs_in;
            cap_rdn  <= rdn_in;
            cap_addr <= alu_in;
            cap_data <= st_data;
        end
    end

    // Registered results towards writeback plus the one-cycle misalign pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbs      <= WB_ALU;
            rdn      <= '0;
            alu_out  <= '0;
            mrd      <= '0;
            misalign <= 1'b0;
        end else begin
            wbs      <= wbs_d;
            rdn      <= rdn_d;
            alu_out  <= alu_d;
            mrd      <= mrd_d;
            misalign <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a transaction-level reference model.
// Latency: expected record per clock edge, compared on the following falling edge.
// Backpressure: the bench holds an upstream op until the model says the stage takes it.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic        vld;
        logic        ld;
        logic        st;
        logic [2:0]  wbs;
        logic [4:0]  rdn;
        logic [31:0] alu;
        logic [31:0] sd;
    } op_t;

    typedef struct packed {
        logic [2:0]  wbs;
        logic [4:0]  rdn;
        logic [31:0] alu;
        logic [31:0] mrd;
        logic        mis;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_in, is_load, is_store;
    logic [2:0]  wbs_in;
    logic [4:0]  rdn_in;
    logic [31:0] alu_in, st_data;
    logic        stall, misalign;
    logic [2:0]  wbs;
    logic [4:0]  rdn;
    logic [31:0] alu_out, mrd;

    always #5 clk = ~clk;

    mem_stage_if #(.WordSize(32)) mem_if ();

    mem_stage #(.WordSize(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .is_load  (is_load),
        .is_store (is_store),
        .wbs_in   (wbs_in),
        .rdn_in   (rdn_in),
        .alu_in   (alu_in),
        .st_data  (st_data),
        .stall    (stall),
        .misalign (misalign),
        .mem      (mem_if),
        .wbs      (wbs),
        .rdn      (rdn),
        .alu_out  (alu_out),
        .mrd      (mrd)
    );

    // Reference model state
    bit          busy;
    op_t         m_op;
    int          m_wait;
    req_t        cur_req;
    bit          exp_busy, exp_stall;
    wb_t         exp_q[$];
    int          checks, errors;
    bit          mon_en;
    int          stall_cnt;
    req_t        seen_req;
    int          force_lat = -1;
    bit          force_rd;
    logic [31:0] forced_rd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wb_t bubble();
        wb_t b;
        b.wbs = 3'd3; b.rdn = '0; b.alu = '0; b.mrd = '0; b.mis = 1'b0;
        return b;
    endfunction

    function automatic int nbytes(input logic [2:0] code);
        if (code == 3'd0 || code == 3'd4) return 1;
        if (code == 3'd1 || code == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input int n);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[(a % 4) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int n);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*(j % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_extract(input logic [31:0] rd, input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = rd[8*((a % 4) + i) +: 8];
        return r;
    endfunction

    function automatic op_t mk(input logic v, input logic l, input logic s, input logic [2:0] w,
                               input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.vld = v; o.ld = l; o.st = s; o.wbs = w; o.rdn = r; o.alu = a; o.sd = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [2:0] lsel [5];
        int k;
        lsel = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        o = mk(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 5)), 5'($urandom), $urandom, $urandom);
        if ($urandom_range(0, 1) == 1) o.alu[1:0] = 2'b00;
        k = $urandom_range(0, 9);
        if (k <= 1) begin
            o.vld = 1'b0; o.ld = 1'($urandom);
        end else if (k >= 5 && k <= 7) begin
            o.ld = 1'b1; o.wbs = lsel[$urandom_range(0, 4)];
        end else if (k == 8) begin
            o.st = 1'b1; o.wbs = 3'($urandom_range(0, 2));
        end else if (k == 9) begin
            o.ld = 1'b1; o.st = 1'b1; o.wbs = lsel[$urandom_range(0, 4)];
        end
        return o;
    endfunction

    // One clock: drive op and memory response, predict the record the edge produces.
    task automatic step(input op_t op, output bit consumed);
        wb_t rec;
        bit ack, busy_n;
        logic [31:0] rd;
        int n;
        valid_in = op.vld; is_load = op.ld; is_store = op.st;
        wbs_in = op.wbs; rdn_in = op.rdn; alu_in = op.alu; st_data = op.sd;
        rd = force_rd ? forced_rd : $urandom;
        ack = 1'b0; busy_n = busy; rec = bubble(); consumed = 1'b0;
        if (busy) begin
            if (m_wait == 0) begin
                ack = 1'b1; busy_n = 1'b0;
                if (m_op.ld) begin
                    rec.wbs = m_op.wbs; rec.rdn = m_op.rdn; rec.alu = m_op.alu;
                    rec.mrd = model_extract(rd, m_op.alu, nbytes(m_op.wbs));
                end
            end else begin
                m_wait--;
            end
        end else begin
            consumed = 1'b1;
            ack = ($urandom_range(0, 3) == 0);
            if (op.vld) begin
                if (!op.ld && !op.st) begin
                    rec.wbs = op.wbs; rec.rdn = op.rdn; rec.alu = op.alu;
                end else begin
                    n = nbytes(op.wbs);
                    if ((op.alu % n) != 0) begin
                        rec.mis = 1'b1;
                    end else begin
                        busy_n = 1'b1; m_op = op;
                        m_wait = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                        cur_req.we    = !op.ld;
                        cur_req.addr  = op.alu - (op.alu % 4);
                        cur_req.be    = model_be(op.alu, n);
                        cur_req.wdata = model_wdata(op.sd, n);
                    end
                end
            end
        end
        mem_if.mem_ack = ack; mem_if.mem_rdata = rd;
        exp_busy = busy; exp_stall = busy && !ack;
        @(posedge clk); #1;
        exp_q.push_back(rec);
        busy = busy_n;
    endtask

    task automatic issue(input op_t op);
        bit c;
        int guard;
        guard = 0;
        do begin
            step(op, c);
            guard++;
        end while (!c && guard < 50);
        if (!c) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic drain();
        bit c;
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            step(mk(1'b0, 1'b0, 1'b0, 3'd3, 5'd0, 32'd0, 32'd0), c);
            guard++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got busy expected idle");
        end
    endtask

    // Monitor: pops the predicted record each falling edge and checks the bus.
    initial begin
        wb_t e, a;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a.wbs = wbs; a.rdn = rdn; a.alu = alu_out; a.mrd = mrd; a.mis = misalign;
                    chk("wb_record", a, e);
                end
                if (exp_busy) begin
                    chk("mem_bus", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata},
                        {1'b1, cur_req});
                end else begin
                    chk("mem_req_idle", mem_if.mem_req, 1'b0);
                end
                chk("stall", stall, exp_stall);
                if (stall) stall_cnt++;
                if (mem_if.mem_req) begin
                    seen_req.we = mem_if.mem_we; seen_req.addr = mem_if.mem_addr;
                    seen_req.be = mem_if.mem_be; seen_req.wdata = mem_if.mem_wdata;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        op_t nop;
        nop = mk(1'b0, 1'b0, 1'b0, 3'd3, 5'd0, 32'd0, 32'd0);
        rstn = 1'b0; valid_in = 0; is_load = 0; is_store = 0; wbs_in = 0; rdn_in = 0;
        alu_in = 0; st_data = 0; mem_if.mem_ack = 0; mem_if.mem_rdata = 0;
        mon_en = 0; busy = 0; checks = 0; errors = 0; stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb", {wbs, rdn, alu_out, mrd, misalign}, bubble());
        chk("reset_bus", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr, mem_if.mem_wdata}, '0);
        chk("reset_stall", stall, 1'b0);
        rstn = 1'b1; mon_en = 1'b1;

        // ALU pass-through
        issue(mk(1'b1, 1'b0, 1'b0, 3'd3, 5'd7, 32'h1234, 32'd0));
        chk("alu_rdn", rdn, 5'd7);
        chk("alu_out", alu_out, 32'h1234);
        chk("alu_noreq", mem_if.mem_req, 1'b0);

        // lb at 0x103, three access cycles
        force_lat = 2; force_rd = 1'b1; forced_rd = 32'hAABBCCDD; stall_cnt = 0;
        issue(mk(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h103, 32'd0));
        drain();
        chk("lb_mrd", mrd, 32'h0000_00AA);
        chk("lb_wbs", wbs, 3'd0);
        chk("lb_stall_cycles", stall_cnt, 2);
        chk("lb_addr", seen_req.addr, 32'h100);
        chk("lb_be", seen_req.be, 4'b1000);
        force_rd = 1'b0;

        // sh at 0x202
        force_lat = 0;
        issue(mk(1'b1, 1'b0, 1'b1, 3'd1, 5'd4, 32'h202, 32'h0000BEEF));
        chk("sh_bubble_rdn", rdn, 5'd0);
        drain();
        chk("sh_be", seen_req.be, 4'b1100);
        chk("sh_wdata", seen_req.wdata, 32'hBEEFBEEF);
        chk("sh_we", seen_req.we, 1'b1);

        // misaligned lw
        issue(mk(1'b1, 1'b1, 1'b0, 3'd2, 5'd8, 32'h101, 32'd0));
        chk("mis_pulse", misalign, 1'b1);
        chk("mis_rdn", rdn, 5'd0);
        chk("mis_noreq", mem_if.mem_req, 1'b0);
        step(nop, c);
        chk("mis_one_cycle", misalign, 1'b0);

        // ALU op waiting on the ack cycle retires right after the load
        force_lat = 1;
        issue(mk(1'b1, 1'b1, 1'b0, 3'd2, 5'd5, 32'h400, 32'd0));
        issue(mk(1'b1, 1'b0, 1'b0, 3'd3, 5'd6, 32'h55, 32'd0));
        chk("b2b_alu_rdn", rdn, 5'd6);
        force_lat = -1;

        // Randomized traffic
        repeat (300) issue(rand_op());
        drain();
        step(nop, c);

        // Reset in the middle of an access
        force_lat = 5;
        issue(mk(1'b1, 1'b1, 1'b0, 3'd2, 5'd3, 32'h80, 32'd0));
        step(nop, c);
        chk("pre_reset_req", mem_if.mem_req, 1'b1);
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk("reset_drop_req", mem_if.mem_req, 1'b0);
        chk("reset_drop_stall", stall, 1'b0);
        chk("reset_drop_wb", {wbs, rdn, alu_out, mrd, misalign}, bubble());
        @(posedge clk);
        #1;
        rstn = 1'b1;
        busy = 1'b0; exp_busy = 1'b0; exp_stall = 1'b0; exp_q.delete();
        mem_if.mem_ack = 1'b0;
        mon_en = 1'b1; force_lat = -1;
        step(nop, c);
        chk("post_reset_bubble", {wbs, rdn, alu_out, mrd, misalign}, bubble());
        issue(mk(1'b1, 1'b0, 1'b0, 3'd3, 5'd11, 32'hCAFE, 32'd0));
        chk("post_reset_alu", rdn, 5'd11);
        step(nop, c);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
